milano_imem: RTL and testbench
==============================

# milano_imem

Instruction memory responder for the milano core fetch interface. It accepts the core's word fetch address and fetch enable and returns instruction data one cycle later. It flags misaligned or out-of-range fetches. After reset it fills itself with NOPs, then takes program images through a valid/ready load port. It sits between the core top and the boot/loader logic, on the responder side of the fetch path.

## Interface
- `DEPTH`, default 1024: number of 32-bit words; power of two, at least 4.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; aligned to DEPTH*4.
- `NOP_INSTR`, default 32'h0000_0013: fill and error-return word (addi x0,x0,0).
- `clk_i` in 1: the single clock. All logic is on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `fetch_enable_i` in 1: fetch request from the core.
- `instr_addr_i` in 32: fetch byte address.
- `instr_rdata_o` out 32: fetched instruction, registered.
- `instr_err_o` out 1: the fetch returned in `instr_rdata_o` was faulty; registered, aligned with `instr_rdata_o`.
- `load_valid_i` in 1: loader has a word.
- `load_ready_o` out 1: memory accepts load words.
- `load_addr_i` in 32: byte address of the load word.
- `load_data_i` in 32: load word.
- `load_err_o` out 1: one-cycle pulse; the accepted load word was dropped.
- `init_done_o` out 1: NOP fill is complete.

## Operation
- **Reset values:** `instr_rdata_o`=NOP_INSTR, `instr_err_o`=0, `load_ready_o`=0, `load_err_o`=0, `init_done_o`=0, state=INIT, fill counter=0.
- **INIT state:**
  - The fill counter writes NOP_INSTR to word `cnt`, one word per cycle, for `cnt` = 0..DEPTH-1.
  - After the write of DEPTH-1, the state moves to READY.
  - Fetches in INIT return NOP_INSTR with err=0 and do not read the array.
- **READY state:** `init_done_o`=1 and `load_ready_o`=1. READY is terminal until reset.
- **Fetch decode:**
  - Word index = (`instr_addr_i` - BASE_ADDR) >> 2, width $clog2(DEPTH).
  - The fetch is faulty if `instr_addr_i[1:0]` != 0, if `instr_addr_i` < BASE_ADDR, or if the offset is ≥ DEPTH*4.
  - A faulty fetch returns NOP_INSTR with err=1.
  - The subtraction is unsigned 32-bit. A wrap below BASE_ADDR counts as out-of-range.
- **fetch_enable_i=0:** `instr_rdata_o` and `instr_err_o` hold their previous values.
- **Load handshake:**
  - A word is accepted when `load_valid_i` && `load_ready_o`.
  - A valid accepted word is written to its array word.
  - A misaligned or out-of-range accepted word is dropped, and `load_err_o`=1 in the next cycle.
  - `load_valid_i` while `load_ready_o`=0 is ignored; the loader must hold it.
- **Simultaneous load write and fetch to the same word:** the read is read-first, so the fetch returns the old data.
- **Reset mid-INIT or mid-READY:** the state returns to INIT with counter=0, and the full fill repeats. Array contents are not otherwise cleared.

## Timing
- Fetch latency is 1 cycle: a request at edge N (enable=1, address A) gives `instr_rdata_o`/`instr_err_o` valid after edge N, usable in cycle N+1.
- A load accepted at edge N is visible to a fetch issued at edge N+1, with data after edge N+1.
- INIT lasts exactly DEPTH cycles after reset deasserts. `init_done_o` and `load_ready_o` rise after edge DEPTH.
- `load_err_o` asserts the cycle after the offending handshake, for one cycle.
- Throughput is one fetch and one load per cycle.

## Configuration
- `MILANO_IMEM_PARITY_EN` defined:
  - Each array word stores a 33rd bit, the even parity of the data, on every write (fill and load).
  - On a fetch, a parity mismatch makes the fault condition true: rdata=NOP_INSTR, err=1.
- Undefined: the array is 32 bits wide, and `instr_err_o` reflects only address faults.

## Structure
- `milano_pkg` gets:
  - `IMEM_NOP` constant.
  - `imem_state_e` enum {IMEM_INIT, IMEM_READY}.
  - Parity helper function, used under the macro.
- Sub-module `imem_ram`:
  - Simple dual-port array: one synchronous write port, one synchronous read-first read port.
  - Width is 32 or 33 depending on the macro.
- `milano_imem` contains the INIT FSM, fill counter, address checks, load handshake and output registers.

## Test plan
- Reset, then count cycles until `init_done_o`=1 → exactly DEPTH cycles. A fetch at 0x0 during INIT → 0x00000013, err=0.
- Load 0xDEADBEEF at 0x8, then fetch 0x8 the next cycle → 0xDEADBEEF one cycle later, err=0.
- Fetch 0x6 (misaligned) and fetch BASE_ADDR+DEPTH*4 → 0x00000013 with err=1 for each. A load to 0x2 → `load_err_o` pulse, array unchanged.
- The same edge carries load 0x11111111 to 0x10 and a fetch of 0x10 → old data; a re-fetch returns 0x11111111.
- Toggle `rst_i` at INIT cycle 100 → fill restarts, done after another DEPTH cycles. With fetch_enable_i=0, outputs hold.
- With `MILANO_IMEM_PARITY_EN`: force the stored parity bit of word 4 inverted, then fetch 0x10 → 0x00000013, err=1.

Source files
------------

// File: rtl/milano_pkg.sv
// milano_pkg: shared constants, types and helpers for the milano core blocks.
// Optional: MILANO_IMEM_PARITY_EN widens instruction memory words with a parity bit.
`default_nettype none

package milano_pkg;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

`ifdef MILANO_IMEM_PARITY_EN
  localparam int IMEM_W = 33;
`else
  localparam int IMEM_W = 32;
`endif

  typedef enum logic [0:0] {
    IMEM_INIT  = 1'b0,
    IMEM_READY = 1'b1
  } imem_state_e;

  // Even parity: the returned bit makes the 33-bit word XOR to zero.
  function automatic logic imem_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/milano_imem_ram.sv
// imem_ram: simple dual-port array, one synchronous write port and one
// synchronous read-first read port. Read data holds while rd_en_i is low.
`default_nettype none

module imem_ram #(
  parameter int DEPTH = 1024,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/milano_imem.sv
// milano_imem: instruction memory responder; NOP fill after reset, then fetch and load.
// Optional: MILANO_IMEM_PARITY_EN stores and checks a per-word even parity bit.
`default_nettype none

module milano_imem
  import milano_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = IMEM_NOP
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic        load_err_o,
  output logic        init_done_o
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  imem_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          fnop_q, fnop_d;
  logic          ferr_q, ferr_d;
  logic          lerr_q, lerr_d;

  logic [31:0]     f_off, l_off;
  logic            f_fault, l_fault, l_accept;
  logic            ram_we, ram_re;
  logic [AW-1:0]   ram_waddr;
  logic [31:0]     wdata32;
  logic [IMEM_W-1:0] ram_wdata, ram_rdata;
  logic            par_bad;

  // Unsigned wrap below BASE_ADDR lands far above SPAN, but the explicit
  // compare keeps the intent obvious.
  assign f_off   = instr_addr_i - BASE_ADDR;
  assign l_off   = load_addr_i - BASE_ADDR;
  assign f_fault = (instr_addr_i[1:0] != 2'b00) || (instr_addr_i < BASE_ADDR) ||
                   ({1'b0, f_off} >= SPAN);
  assign l_fault = (load_addr_i[1:0] != 2'b00) || (load_addr_i < BASE_ADDR) ||
                   ({1'b0, l_off} >= SPAN);

  assign load_ready_o = (state_q == IMEM_READY);
  assign init_done_o  = (state_q == IMEM_READY);
  assign l_accept     = load_valid_i && load_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fnop_d    = fnop_q;
    ferr_d    = ferr_q;
    lerr_d    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = l_off[AW+1:2];
    wdata32   = load_data_i;
    if (state_q == IMEM_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_q;
      wdata32   = NOP_INSTR;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == AW'(DEPTH - 1)) state_d = IMEM_READY;
      if (fetch_enable_i) begin
        fnop_d = 1'b1;
        ferr_d = 1'b0;
      end
    end else begin
      ram_we = l_accept && !l_fault;
      lerr_d = l_accept && l_fault;
      if (fetch_enable_i) begin
        fnop_d = f_fault;
        ferr_d = f_fault;
        ram_re = !f_fault;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IMEM_INIT;
      cnt_q   <= '0;
      fnop_q  <= 1'b1;
      ferr_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fnop_q  <= fnop_d;
      ferr_q  <= ferr_d;
      lerr_q  <= lerr_d;
    end
  end

`ifdef MILANO_IMEM_PARITY_EN
  assign ram_wdata = {imem_parity(wdata32), wdata32};
  assign par_bad   = !fnop_q && (^ram_rdata);
`else
  assign ram_wdata = wdata32;
  assign par_bad   = 1'b0;
`endif

  imem_ram #(
    .DEPTH (DEPTH),
    .W     (IMEM_W),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (ram_we),
    .wr_addr_i (ram_waddr),
    .wr_data_i (ram_wdata),
    .rd_en_i   (ram_re),
    .rd_addr_i (f_off[AW+1:2]),
    .rd_data_o (ram_rdata)
  );

  // The read register only updates on good fetches, so NOP/err flags ride alongside it.
  assign instr_rdata_o = (fnop_q || par_bad) ? NOP_INSTR : ram_rdata[31:0];
  assign instr_err_o   = ferr_q || par_bad;
  assign load_err_o    = lerr_q;

endmodule

`default_nettype wire

// File: tb/tb_milano_imem.sv
// tb_milano_imem: directed self-checking bench for milano_imem (DEPTH=128, BASE=0).
`default_nettype none

module tb_milano_imem;

  localparam int          DEPTH = 128;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_enable_i;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        load_valid_i;
  logic        load_ready_o;
  logic [31:0] load_addr_i;
  logic [31:0] load_data_i;
  logic        load_err_o;
  logic        init_done_o;

  int checks   = 0;
  int failures = 0;
  int cycles;

  milano_imem #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fetch_enable_i (fetch_enable_i),
    .instr_addr_i   (instr_addr_i),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .load_valid_i   (load_valid_i),
    .load_ready_o   (load_ready_o),
    .load_addr_i    (load_addr_i),
    .load_data_i    (load_data_i),
    .load_err_o     (load_err_o),
    .init_done_o    (init_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_enable_i = 1'b1;
    instr_addr_i   = a;
    tick();
    fetch_enable_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start);
    cycles = start;
    while (!init_done_o && cycles < 4 * DEPTH) begin
      tick();
      cycles++;
    end
    chk(tag, 32'(cycles), 32'(DEPTH));
  endtask

  initial begin
    rst_i = 1'b1; fetch_enable_i = 1'b0; instr_addr_i = '0;
    load_valid_i = 1'b0; load_addr_i = '0; load_data_i = '0;
    tick(); tick();
    chk("rst_rdata", instr_rdata_o, NOP);
    chk("rst_err",   32'(instr_err_o),  0);
    chk("rst_ready", 32'(load_ready_o), 0);
    chk("rst_done",  32'(init_done_o),  0);
    chk("rst_lerr",  32'(load_err_o),   0);

    // First INIT edge also carries a fetch of 0x0.
    rst_i = 1'b0;
    fetch(32'h0);
    chk("init_fetch_rdata", instr_rdata_o, NOP);
    chk("init_fetch_err",   32'(instr_err_o), 0);
    wait_done("init_len", 1);
    chk("ready_hi", 32'(load_ready_o), 1);

    load_valid_i = 1'b1; load_addr_i = 32'h8; load_data_i = 32'hDEAD_BEEF;
    tick();
    load_valid_i = 1'b0;
    chk("load_ok_lerr", 32'(load_err_o), 0);
    fetch(32'h8);
    chk("ld_fetch_rdata", instr_rdata_o, 32'hDEAD_BEEF);
    chk("ld_fetch_err",   32'(instr_err_o), 0);

    fetch(32'h6);
    chk("misal_rdata", instr_rdata_o, NOP);
    chk("misal_err",   32'(instr_err_o), 1);
    // With enable low both outputs keep the faulty result.
    instr_addr_i = 32'h8;
    tick();
    chk("hold_err_rdata", instr_rdata_o, NOP);
    chk("hold_err",       32'(instr_err_o), 1);

    fetch(32'(DEPTH * 4));
    chk("oor_rdata", instr_rdata_o, NOP);
    chk("oor_err",   32'(instr_err_o), 1);
    fetch(32'(DEPTH * 4 - 4));
    chk("last_rdata", instr_rdata_o, NOP);
    chk("last_err",   32'(instr_err_o), 0);
    fetch(32'hFFFF_FFFC);
    chk("wrap_err", 32'(instr_err_o), 1);

    load_valid_i = 1'b1; load_addr_i = 32'h2; load_data_i = 32'hBAD0_BAD0;
    tick();
    load_valid_i = 1'b0;
    chk("lerr_pulse", 32'(load_err_o), 1);
    tick();
    chk("lerr_drop", 32'(load_err_o), 0);
    fetch(32'h0);
    chk("drop_w0", instr_rdata_o, NOP);

    // Same-edge load and fetch of word 4: read-first returns the fill value.
    load_valid_i = 1'b1; load_addr_i = 32'h10; load_data_i = 32'h1111_1111;
    fetch(32'h10);
    load_valid_i = 1'b0;
    chk("rf_old", instr_rdata_o, NOP);
    fetch(32'h10);
    chk("rf_new", instr_rdata_o, 32'h1111_1111);
    instr_addr_i = 32'h8;
    tick(); tick();
    chk("hold_rdata", instr_rdata_o, 32'h1111_1111);
    chk("hold_noerr", 32'(instr_err_o), 0);
    fetch(32'h8);
    chk("w2_keep", instr_rdata_o, 32'hDEAD_BEEF);

    // Reset 100 cycles into a fresh fill; the fill must restart from zero.
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    repeat (100) tick();
    chk("mid_init_done", 32'(init_done_o), 0);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("rerst_ready", 32'(load_ready_o), 0);
    wait_done("refill_len", 0);
    fetch(32'h10);
    chk("refill_w4", instr_rdata_o, NOP);

`ifdef MILANO_IMEM_PARITY_EN
    dut.u_ram.mem_q[4][32] = ~dut.u_ram.mem_q[4][32];
    fetch(32'h10);
    chk("par_rdata", instr_rdata_o, NOP);
    chk("par_err",   32'(instr_err_o), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
